// File: rtl/shift_pkg.sv
// Shared mode encoding for the universal shift register.
// Two-bit mode is fully decoded; every value has a meaning.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

endpackage

// File: rtl/tick_divider.sv
// Prescaler producing a one-cycle step strobe every DIV clocks.
// run gates the strobe so nothing steps on the first edge out of reset.
module tick_divider #(
  parameter int DIV = 100_000_000
) (
  input  logic clk,
  input  logic clr_n,
  input  logic sync_clr,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic          run;
  logic [PW-1:0] presc;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      run   <= 1'b0;
      presc <= '0;
    end else begin
      run <= 1'b1;
      if (sync_clr) begin
        presc <= '0;
      end else if (run) begin
        presc <= (presc == LAST) ? '0 : presc + PW'(1);
      end
    end
  end

  assign tick = run & (presc == LAST);

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left, parallel load,
// stepped by a prescaler strobe, with a frame pulse every WIDTH shifts.
import shift_pkg::*;

module univ_shift_reg #(
  parameter int WIDTH = 4,
  parameter int DIV   = 100_000_000
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             sync_clr,
  input  logic [1:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             tick,
  output logic             frame_done
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam logic [FW-1:0] CNT_LAST = FW'(WIDTH - 1);

  if (WIDTH < 2 || DIV < 1) begin : g_bad_param
    $error("univ_shift_reg: WIDTH must be >= 2 and DIV >= 1");
  end

  mode_t         m;
  logic [FW-1:0] cnt;

  assign m = mode_t'(mode);

  tick_divider #(
    .DIV(DIV)
  ) u_div (
    .clk      (clk),
    .clr_n    (clr_n),
    .sync_clr (sync_clr),
    .tick     (tick)
  );

  // A shift that completes a frame wraps the count and fires the pulse.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q          <= '0;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else if (sync_clr) begin
      q          <= '0;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (tick) begin
        unique case (m)
          MODE_HOLD: ;
          MODE_SHR: begin
            q <= {sin_l, q[WIDTH-1:1]};
            if (cnt == CNT_LAST) begin
              cnt        <= '0;
              frame_done <= 1'b1;
            end else begin
              cnt <= cnt + FW'(1);
            end
          end
          MODE_SHL: begin
            q <= {q[WIDTH-2:0], sin_r};
            if (cnt == CNT_LAST) begin
              cnt        <= '0;
              frame_done <= 1'b1;
            end else begin
              cnt <= cnt + FW'(1);
            end
          end
          MODE_LOAD: begin
            q   <= pdata;
            cnt <= '0;
          end
        endcase
      end
    end
  end

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: DIV=3 and DIV=1 instances
// share inputs; each step checks hand-computed values.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       sync_clr;
  logic [1:0] mode;
  logic       sin_l;
  logic       sin_r;
  logic [3:0] pdata;

  logic [3:0] q, q1;
  logic       sout_r, sout_l, tick, frame_done;
  logic       sout_r1, sout_l1, tick1, frame_done1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(4), .DIV(3)) dut (
    .clk(clk), .clr_n(clr_n), .sync_clr(sync_clr), .mode(mode),
    .sin_l(sin_l), .sin_r(sin_r), .pdata(pdata), .q(q),
    .sout_r(sout_r), .sout_l(sout_l), .tick(tick),
    .frame_done(frame_done)
  );

  univ_shift_reg #(.WIDTH(4), .DIV(1)) dut1 (
    .clk(clk), .clr_n(clr_n), .sync_clr(sync_clr), .mode(mode),
    .sin_l(sin_l), .sin_r(sin_r), .pdata(pdata), .q(q1),
    .sout_r(sout_r1), .sout_l(sout_l1), .tick(tick1),
    .frame_done(frame_done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for tick, then pass the edge that consumes it.
  task automatic do_tick();
    int n = 0;
    while (tick !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8) chk("tick_timeout", 32'(tick), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic [3:0] eq,
                          input logic efd);
    do_tick();
    chk({tag, "_q"}, 32'(q), 32'(eq));
    chk({tag, "_fd"}, 32'(frame_done), 32'(efd));
  endtask

  task automatic release_seq(input string tag);
    @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk(tag, 32'(tick), 32'(i == 2));
    end
  endtask

  logic [3:0] t6_q [8];
  logic       t6_fd [8];

  initial begin
    clr_n = 1'b0; sync_clr = 1'b0; mode = 2'b00;
    sin_l = 1'b0; sin_r = 1'b0; pdata = 4'h0;
    #1;
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_fd", 32'(frame_done), 32'h0);
    repeat (2) @(posedge clk);
    release_seq("first_tick");

    // T2 shift right with ones, frame after 4th shift
    mode = 2'b01; sin_l = 1'b1;
    step_chk("t2_s1", 4'b1000, 1'b0);
    step_chk("t2_s2", 4'b1100, 1'b0);
    step_chk("t2_s3", 4'b1110, 1'b0);
    step_chk("t2_s4", 4'b1111, 1'b1);
    @(posedge clk); #1;
    chk("t2_fd_drop", 32'(frame_done), 32'h0);

    // T1 reset mid-count
    sin_l = 1'b0;
    step_chk("t1_pre", 4'b0111, 1'b0);
    @(posedge clk); #1;
    clr_n = 1'b0;
    #1;
    chk("t1_q", 32'(q), 32'h0);
    chk("t1_tick", 32'(tick), 32'h0);
    chk("t1_fd", 32'(frame_done), 32'h0);
    release_seq("t1_first_tick");

    // T3 load then shift left
    mode = 2'b11; pdata = 4'b1010;
    step_chk("t3_ld", 4'b1010, 1'b0);
    chk("t3_sout_r", 32'(sout_r), 32'h0);
    mode = 2'b10; sin_r = 1'b0;
    step_chk("t3_s1", 4'b0100, 1'b0);
    chk("t3_sl1", 32'(sout_l), 32'h0);
    step_chk("t3_s2", 4'b1000, 1'b0);
    chk("t3_sl2", 32'(sout_l), 32'h1);
    step_chk("t3_s3", 4'b0000, 1'b0);
    chk("t3_sl3", 32'(sout_l), 32'h0);

    // T4 count survives hold and direction change
    mode = 2'b11; pdata = 4'b0000;
    step_chk("t4_ld", 4'b0000, 1'b0);
    mode = 2'b01; sin_l = 1'b1;
    step_chk("t4_r1", 4'b1000, 1'b0);
    step_chk("t4_r2", 4'b1100, 1'b0);
    mode = 2'b00;
    step_chk("t4_h1", 4'b1100, 1'b0);
    step_chk("t4_h2", 4'b1100, 1'b0);
    step_chk("t4_h3", 4'b1100, 1'b0);
    mode = 2'b10; sin_r = 1'b1;
    step_chk("t4_l1", 4'b1001, 1'b0);
    chk("t4_sout_r", 32'(sout_r), 32'h1);
    step_chk("t4_l2", 4'b0011, 1'b1);
    @(posedge clk); #1;
    chk("t4_fd_drop", 32'(frame_done), 32'h0);

    // T5 sync_clr beats load on a tick edge
    mode = 2'b01; sin_l = 1'b0;
    step_chk("t5_pre", 4'b0001, 1'b0);
    mode = 2'b11; pdata = 4'b1111;
    begin
      int n = 0;
      while (tick !== 1'b1 && n < 8) begin
        @(negedge clk);
        n++;
      end
      chk("t5_tick_seen", 32'(tick), 32'h1);
    end
    sync_clr = 1'b1;
    @(posedge clk); #1;
    sync_clr = 1'b0;
    chk("t5_q", 32'(q), 32'h0);
    chk("t5_tick0", 32'(tick), 32'h0);
    @(posedge clk); #1;
    chk("t5_tick1", 32'(tick), 32'h0);
    @(posedge clk); #1;
    chk("t5_tick2", 32'(tick), 32'h1);
    mode = 2'b01; sin_l = 1'b1;
    step_chk("t5_s1", 4'b1000, 1'b0);
    step_chk("t5_s2", 4'b1100, 1'b0);
    step_chk("t5_s3", 4'b1110, 1'b0);
    step_chk("t5_s4", 4'b1111, 1'b1);

    // T6 DIV=1 instance steps every cycle
    t6_q = '{4'b1000, 4'b0100, 4'b1010, 4'b0101,
             4'b1010, 4'b0101, 4'b1010, 4'b0101};
    t6_fd = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    sync_clr = 1'b1; mode = 2'b01;
    @(posedge clk); #1;
    sync_clr = 1'b0;
    chk("t6_clr_q", 32'(q1), 32'h0);
    for (int i = 0; i < 8; i++) begin
      sin_l = (i % 2 == 0);
      chk("t6_tick", 32'(tick1), 32'h1);
      @(posedge clk); #1;
      chk("t6_q", 32'(q1), 32'(t6_q[i]));
      chk("t6_fd", 32'(frame_done1), 32'(t6_fd[i]));
    end
    chk("t6_sout_l", 32'(sout_l1), 32'h0);
    chk("t6_sout_r", 32'(sout_r1), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
